// File: rtl/switch_traversal_stage_pkg.sv
// Shared sizing and FPV port-index constants for the switch traversal stage.
package switch_traversal_stage_pkg;
   localparam int NUM_CHANNEL = 5;
   localparam int NUM_PORT    = 6;
   localparam int WIDTH_FLIT  = 64;
   localparam int SB_DEPTH    = 8;

   localparam int PORT_N      = 0;
   localparam int PORT_E      = 1;
   localparam int PORT_S      = 2;
   localparam int PORT_W      = 3;
   localparam int PORT_L      = 4;
   localparam int PORT_BYPASS = 5;
   localparam int NUM_OUT     = PORT_L + 1;

   function automatic logic pv_onehot(input logic [NUM_PORT-1:0] pv);
      return (pv != '0) && ((pv & (pv - 1'b1)) == '0);
   endfunction
endpackage

// File: rtl/switch_traversal_stage_side_buffer_fifo.sv
// Circular side buffer: up to NCH in-order writes per cycle, one read per cycle.
// Writes that do not fit are refused from the highest channel down.
module side_buffer_fifo
   import switch_traversal_stage_pkg::*;
#(
   parameter int NCH   = NUM_CHANNEL,
   parameter int W     = WIDTH_FLIT,
   parameter int DEPTH = SB_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NCH-1:0]             wr_valid,
   input  logic [NCH*W-1:0]           wr_data,
   input  logic                       rd_ready,
   output logic                       rd_valid,
   output logic [W-1:0]               rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic [$clog2(NCH+1)-1:0]   drop_n
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]              mem_q [DEPTH];
   logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]             count_q, space, enq_n;
   logic [NCH-1:0]            acc;
   logic [NCH-1:0][PW-1:0]    waddr;
   logic                      deq;

   // A slot freed by this cycle's read can be refilled on the same edge.
   always_comb begin
      deq    = rd_valid & rd_ready;
      space  = CW'(DEPTH) - count_q + CW'(deq);
      enq_n  = '0;
      drop_n = '0;
      acc    = '0;
      waddr  = '0;
      for (int i = 0; i < NCH; i++) begin
         waddr[i] = wr_ptr_q + PW'(enq_n);
         if (wr_valid[i]) begin
            if (enq_n < space) begin
               acc[i] = 1'b1;
               enq_n  = enq_n + 1'b1;
            end else begin
               drop_n = drop_n + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + PW'(enq_n);
         if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q  <= count_q + enq_n - CW'(deq);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++)
         if (acc[i]) mem_q[waddr[i]] <= wr_data[i*W +: W];
   end

   assign rd_valid = (count_q != '0);
   assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
   assign count    = count_q;
endmodule

// File: rtl/switch_traversal_stage.sv
// Registers allocator flits + FPVs, drives the crossbar onto N/E/S/W/L and diverts
// bypass flits into a re-injection side buffer; tracks drops and errors.
module switch_traversal_stage #(
   parameter int NUM_CHANNEL = switch_traversal_stage_pkg::NUM_CHANNEL,
   parameter int NUM_PORT    = switch_traversal_stage_pkg::NUM_PORT,
   parameter int WIDTH_FLIT  = switch_traversal_stage_pkg::WIDTH_FLIT,
   parameter int SB_DEPTH    = switch_traversal_stage_pkg::SB_DEPTH
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_CHANNEL*WIDTH_FLIT-1:0] flit_in,
   input  logic [NUM_CHANNEL*NUM_PORT-1:0]   pv_in,
   input  logic [NUM_CHANNEL-1:0]            valid_in,
   output logic [5*WIDTH_FLIT-1:0]           out_flit,
   output logic [4:0]                        out_valid,
   output logic [WIDTH_FLIT-1:0]             reinj_flit,
   output logic                              reinj_valid,
   input  logic                              reinj_ready,
   output logic [$clog2(SB_DEPTH):0]         sb_count,
   output logic                              sb_full,
   output logic                              err_sticky,
   output logic [15:0]                       drop_cnt
);
   import switch_traversal_stage_pkg::*;

   localparam int DW = $clog2(NUM_CHANNEL+1);

   logic [NUM_CHANNEL-1:0]                  valid_q;
   logic [NUM_CHANNEL-1:0][WIDTH_FLIT-1:0]  flit_q;
   logic [NUM_CHANNEL-1:0][NUM_PORT-1:0]    pv_q;
   logic [15:0]                             drop_cnt_q, drop_cnt_d;
   logic                                    err_q, err_d;

   logic [NUM_CHANNEL-1:0]                  ok, byp;
   logic [NUM_OUT-1:0][WIDTH_FLIT-1:0]      xbar;
   logic [NUM_OUT-1:0]                      xvld;
   logic [DW-1:0]                           n_lose, n_bad, sb_drop;
   logic [16:0]                             drop_sum;

   always_ff @(posedge clk) begin
      if (reset) valid_q <= '0;
      else       valid_q <= valid_in;
      flit_q <= flit_in;
      pv_q   <= pv_in;
   end

   // Malformed PVs never reach the crossbar or buffer; lowest channel wins a port.
   always_comb begin
      ok     = '0;
      byp    = '0;
      xbar   = '0;
      xvld   = '0;
      n_lose = '0;
      n_bad  = '0;
      for (int i = 0; i < NUM_CHANNEL; i++) begin
         ok[i]  = valid_q[i] & pv_onehot(pv_q[i]);
         byp[i] = ok[i] & pv_q[i][PORT_BYPASS];
         if (valid_q[i] && !ok[i]) n_bad = n_bad + 1'b1;
      end
      for (int p = 0; p < NUM_OUT; p++) begin
         for (int i = 0; i < NUM_CHANNEL; i++) begin
            if (ok[i] && pv_q[i][p]) begin
               if (!xvld[p]) begin
                  xvld[p] = 1'b1;
                  xbar[p] = flit_q[i];
               end else begin
                  n_lose = n_lose + 1'b1;
               end
            end
         end
      end
   end

   side_buffer_fifo #(
      .NCH   (NUM_CHANNEL),
      .W     (WIDTH_FLIT),
      .DEPTH (SB_DEPTH)
   ) u_sb (
      .clk      (clk),
      .reset    (reset),
      .wr_valid (byp),
      .wr_data  (flit_q),
      .rd_ready (reinj_ready),
      .rd_valid (reinj_valid),
      .rd_data  (reinj_flit),
      .count    (sb_count),
      .drop_n   (sb_drop)
   );

   always_comb begin
      drop_sum   = {1'b0, drop_cnt_q} + 17'(n_lose) + 17'(n_bad) + 17'(sb_drop);
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      err_d      = err_q | (n_lose != '0) | (n_bad != '0) | (sb_drop != '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
         err_q      <= err_d;
      end
   end

   assign out_flit   = xbar;
   assign out_valid  = xvld;
   assign sb_full    = (sb_count == ($clog2(SB_DEPTH)+1)'(SB_DEPTH));
   assign err_sticky = err_q;
   assign drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_switch_traversal_stage.sv
// Directed bench: crossbar results and re-injected flits are queued as expectations
// when stimulus is driven and compared when the stage produces them.
module tb_switch_traversal_stage;
   localparam int NCH = 5;
   localparam int W   = 64;

   typedef struct packed {
      logic [4:0]     ov;
      logic [5*W-1:0] fl;
   } xb_t;

   logic                  clk, reset;
   logic [NCH-1:0][W-1:0] fl;
   logic [NCH-1:0][5:0]   pv;
   logic [NCH-1:0]        v;
   logic [5*W-1:0]        out_flit;
   logic [4:0]            out_valid;
   logic [W-1:0]          reinj_flit;
   logic                  reinj_valid, reinj_ready, sb_full, err_sticky;
   logic [3:0]            sb_count;
   logic [15:0]           drop_cnt;

   int        checks = 0;
   int        errors = 0;
   xb_t       xq[$];
   logic [W-1:0] rq[$];

   switch_traversal_stage dut (
      .clk         (clk),
      .reset       (reset),
      .flit_in     (fl),
      .pv_in       (pv),
      .valid_in    (v),
      .out_flit    (out_flit),
      .out_valid   (out_valid),
      .reinj_flit  (reinj_flit),
      .reinj_valid (reinj_valid),
      .reinj_ready (reinj_ready),
      .sb_count    (sb_count),
      .sb_full     (sb_full),
      .err_sticky  (err_sticky),
      .drop_cnt    (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic logic [W-1:0] mk(input int k, input int i);
      return {32'(32'hC0DE_0000 + k), 32'(i)};
   endfunction

   task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input int k, input logic [4:0] vv, input logic [5:0] p [5]);
      for (int i = 0; i < NCH; i++) begin
         fl[i] = mk(k, i);
         pv[i] = p[i];
      end
      v = vv;
   endtask

   task automatic push_xbar(input logic [4:0] ov, input int s [5]);
      xb_t e;
      e.ov = ov;
      e.fl = '0;
      for (int p = 0; p < 5; p++)
         if (ov[p]) e.fl[p*W +: W] = fl[s[p]];
      xq.push_back(e);
   endtask

   task automatic push_idle();
      push_xbar(5'b0, '{0, 0, 0, 0, 0});
   endtask

   task automatic check_xbar(input string tag);
      xb_t e;
      chk({tag, "_xq"}, 320'(xq.size() != 0), 320'(1));
      if (xq.size() != 0) begin
         e = xq.pop_front();
         chk({tag, "_ov"}, 320'(out_valid), 320'(e.ov));
         chk({tag, "_flit"}, 320'(out_flit), 320'(e.fl));
      end
   endtask

   task automatic deq_check(input string tag);
      chk({tag, "_valid"}, 320'(reinj_valid), 320'(rq.size() != 0));
      if (rq.size() != 0) chk({tag, "_flit"}, 320'(reinj_flit), 320'(rq.pop_front()));
   endtask

   initial begin
      int n;
      reset = 1'b1; v = '0; pv = '0; fl = '0; reinj_ready = 1'b0;
      cycle(); cycle();
      chk("rst_out_valid", 320'(out_valid), 320'(0));
      chk("rst_out_flit", 320'(out_flit), 320'(0));
      chk("rst_reinj_valid", 320'(reinj_valid), 320'(0));
      chk("rst_reinj_flit", 320'(reinj_flit), 320'(0));
      chk("rst_sb_count", 320'(sb_count), 320'(0));
      chk("rst_sb_full", 320'(sb_full), 320'(0));
      chk("rst_err", 320'(err_sticky), 320'(0));
      chk("rst_drop", 320'(drop_cnt), 320'(0));
      reset = 1'b0;

      // N + L, with invalid channels carrying PVs that must be ignored
      drive(1, 5'b00101, '{6'b000001, 6'b000001, 6'b010000, 6'b000000, 6'b100000});
      push_xbar(5'b10001, '{0, 0, 0, 0, 2});
      cycle(); check_xbar("t1");
      v = '0; push_idle(); cycle(); check_xbar("t1_idle");
      chk("t1_err", 320'(err_sticky), 320'(0));
      chk("t1_drop", 320'(drop_cnt), 320'(0));
      chk("t1_sb", 320'(sb_count), 320'(0));

      // conflict on S: ch1 wins, ch3 dropped
      drive(2, 5'b01010, '{6'b0, 6'b000100, 6'b0, 6'b000100, 6'b0});
      push_xbar(5'b00100, '{0, 0, 1, 0, 0});
      cycle(); check_xbar("t2");
      v = '0; push_idle(); cycle(); check_xbar("t2_idle");
      chk("t2_drop", 320'(drop_cnt), 320'(1));
      chk("t2_err", 320'(err_sticky), 320'(1));

      // zero PV and multi-hot PV dropped, good W flit delivered
      drive(3, 5'b10101, '{6'b000000, 6'b0, 6'b001000, 6'b0, 6'b000011});
      push_xbar(5'b01000, '{0, 0, 0, 2, 0});
      cycle(); check_xbar("t3");
      v = '0; push_idle(); cycle(); check_xbar("t3_idle");
      chk("t3_drop", 320'(drop_cnt), 320'(3));

      // five bypass flits, then five more into three free slots
      drive(4, 5'b11111, '{6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b100000});
      push_idle(); cycle(); check_xbar("t4a");
      for (int i = 0; i < NCH; i++) rq.push_back(mk(4, i));
      drive(5, 5'b11111, '{6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b100000});
      push_idle(); cycle(); check_xbar("t4b");
      chk("t4_sb5", 320'(sb_count), 320'(5));
      chk("t4_head_valid", 320'(reinj_valid), 320'(1));
      chk("t4_head", 320'(reinj_flit), 320'(rq[0]));
      for (int i = 0; i < 3; i++) rq.push_back(mk(5, i));
      v = '0; push_idle(); cycle(); check_xbar("t4c");
      chk("t4_sb8", 320'(sb_count), 320'(8));
      chk("t4_full", 320'(sb_full), 320'(1));
      chk("t4_drop", 320'(drop_cnt), 320'(5));

      // full buffer, dequeue and enqueue on the same edge
      drive(6, 5'b00100, '{6'b0, 6'b0, 6'b100000, 6'b0, 6'b0});
      push_idle(); cycle(); check_xbar("t5a");
      v = '0; reinj_ready = 1'b1;
      deq_check("t5_deq");
      rq.push_back(mk(6, 2));
      push_idle(); cycle(); check_xbar("t5b");
      reinj_ready = 1'b0;
      chk("t5_sb8", 320'(sb_count), 320'(8));
      chk("t5_full", 320'(sb_full), 320'(1));
      chk("t5_drop", 320'(drop_cnt), 320'(5));

      // head must hold while not accepted
      for (int c = 0; c < 3; c++) begin
         chk("t6_hold_valid", 320'(reinj_valid), 320'(1));
         chk("t6_hold_flit", 320'(reinj_flit), 320'(rq[0]));
         cycle();
      end
      reinj_ready = 1'b1;
      n = 0;
      while (rq.size() != 0 && n < 20) begin
         deq_check("t6_drain");
         cycle();
         n++;
      end
      chk("t6_drain_left", 320'(rq.size()), 320'(0));
      chk("t6_empty_valid", 320'(reinj_valid), 320'(0));
      chk("t6_empty_sb", 320'(sb_count), 320'(0));
      reinj_ready = 1'b0;

      // reset with four buffered flits and a conflict in the stage registers
      drive(7, 5'b01111, '{6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b0});
      push_idle(); cycle(); check_xbar("t7a");
      drive(8, 5'b00011, '{6'b000001, 6'b000001, 6'b0, 6'b0, 6'b0});
      push_xbar(5'b00001, '{0, 0, 0, 0, 0});
      cycle(); check_xbar("t7b");
      chk("t7_sb4", 320'(sb_count), 320'(4));
      reset = 1'b1; v = '0;
      cycle();
      rq.delete();
      chk("t7_sb", 320'(sb_count), 320'(0));
      chk("t7_reinj_valid", 320'(reinj_valid), 320'(0));
      chk("t7_reinj_flit", 320'(reinj_flit), 320'(0));
      chk("t7_out_valid", 320'(out_valid), 320'(0));
      chk("t7_drop", 320'(drop_cnt), 320'(0));
      chk("t7_err", 320'(err_sticky), 320'(0));
      reset = 1'b0;
      cycle(); cycle();
      chk("t7_post_valid", 320'(reinj_valid), 320'(0));
      chk("t7_post_drop", 320'(drop_cnt), 320'(0));

      // drop counter saturation: five bad PVs per cycle
      drive(9, 5'b11111, '{6'b0, 6'b0, 6'b0, 6'b0, 6'b0});
      repeat (13200) cycle();
      chk("t8_sat", 320'(drop_cnt), 320'(16'hFFFF));
      cycle();
      chk("t8_hold", 320'(drop_cnt), 320'(16'hFFFF));
      chk("t8_err", 320'(err_sticky), 320'(1));
      v = '0;
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
